regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 32x32 register file's single write port. It accepts register-write requests from two producers: port A (ALU/execute result) and port B (load/store unit return data). Each port has its own one-entry buffer, and the arbiter drains the buffers in age order into a registered `wr_en`/`w1`/`data` triple feeding the register file. It also publishes a per-register pending-write vector that the decode stage uses for hazard stalls.

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file write-back arbiter: two producer request
// ports, the registered write port, the flush control and the per-register busy vector.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic                 flush;
    logic                 a_valid;
    logic                 a_ready;
    logic [AW-1:0]        a_rd;
    logic [DW-1:0]        a_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [AW-1:0]        b_rd;
    logic [DW-1:0]        b_data;
    logic                 wr_en;
    logic [AW-1:0]        w1;
    logic [DW-1:0]        data;
    logic [(2**AW)-1:0]   busy;

    // master: producers and decode side; slave: the arbiter
    modport master (
        output flush, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, wr_en, w1, data, busy
    );
    modport slave (
        input  flush, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, wr_en, w1, data, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-producer write-back arbiter for the register file's single write port.
// One-entry buffer per port, drained oldest-first; ties broken by a round-robin bit.
module regfile_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NR = 2 ** AW;

    logic            a_vld_reg, a_vld_next;
    logic            b_vld_reg, b_vld_next;
    logic [AW-1:0]   a_rd_reg, b_rd_reg;
    logic [DW-1:0]   a_dat_reg, b_dat_reg;
    logic            older_reg, older_next;
    logic            tie_reg, tie_next;
    logic            rr_reg, rr_next;
    logic            wr_en_reg;
    logic [AW-1:0]   w1_reg;
    logic [DW-1:0]   data_reg;

    logic            pick_b;
    logic            grant_a, grant_b;
    logic            drain_a, drain_b;
    logic            a_ready_int, b_ready_int;
    logic            a_load, b_load;
    logic [NR-1:0]   busy_vec;

    // Grant depends only on buffered state, never on the incoming valids.
    assign pick_b  = tie_reg ? rr_reg : older_reg;
    assign grant_a = a_vld_reg && !(b_vld_reg && pick_b);
    assign grant_b = b_vld_reg && !(a_vld_reg && !pick_b);

    // A flush suppresses the grant so a buffered loser can never reach the output.
    assign drain_a = grant_a && !bus.flush;
    assign drain_b = grant_b && !bus.flush;

    assign a_ready_int = rst && !bus.flush && (!a_vld_reg || grant_a);
    assign b_ready_int = rst && !bus.flush && (!b_vld_reg || grant_b);

    // Writes to x0 complete the handshake but are never buffered.
    assign a_load = bus.a_valid && a_ready_int && (bus.a_rd != '0);
    assign b_load = bus.b_valid && b_ready_int && (bus.b_rd != '0);

    assign a_vld_next = !bus.flush && (a_load || (a_vld_reg && !drain_a));
    assign b_vld_next = !bus.flush && (b_load || (b_vld_reg && !drain_b));

    always_comb begin
        older_next = older_reg;
        tie_next   = tie_reg;
        rr_next    = rr_reg;
        if (bus.flush) begin
            older_next = 1'b0;
            tie_next   = 1'b0;
        end else begin
            if (a_vld_next && b_vld_next) begin
                if (a_load && b_load) begin
                    tie_next = 1'b1;
                end else if (a_load) begin
                    older_next = 1'b1;
                    tie_next   = 1'b0;
                end else if (b_load) begin
                    older_next = 1'b0;
                    tie_next   = 1'b0;
                end
            end else begin
                tie_next = 1'b0;
            end
            if (a_vld_reg && b_vld_reg && tie_reg) begin
                rr_next = !rr_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_vld_reg <= 1'b0;
            b_vld_reg <= 1'b0;
            a_rd_reg  <= '0;
            b_rd_reg  <= '0;
            a_dat_reg <= '0;
            b_dat_reg <= '0;
            older_reg <= 1'b0;
            tie_reg   <= 1'b0;
            rr_reg    <= 1'b0;
        end else begin
            a_vld_reg <= a_vld_next;
            b_vld_reg <= b_vld_next;
            older_reg <= older_next;
            tie_reg   <= tie_next;
            rr_reg    <= rr_next;
            if (a_load) begin
                a_rd_reg  <= bus.a_rd;
                a_dat_reg <= bus.a_data;
            end
            if (b_load) begin
                b_rd_reg  <= bus.b_rd;
                b_dat_reg <= bus.b_data;
            end
        end
    end

    // Output register holds index/data when idle; only wr_en drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_reg <= 1'b0;
            w1_reg    <= '0;
            data_reg  <= '0;
        end else begin
            wr_en_reg <= drain_a || drain_b;
            if (drain_b) begin
                w1_reg   <= b_rd_reg;
                data_reg <= b_dat_reg;
            end else if (drain_a) begin
                w1_reg   <= a_rd_reg;
                data_reg <= a_dat_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_busy
            assign busy_vec[gi] = (a_vld_reg && (a_rd_reg == AW'(gi)))
                                | (b_vld_reg && (b_rd_reg == AW'(gi)))
                                | (wr_en_reg && (w1_reg == AW'(gi)));
        end
    endgenerate

    assign bus.a_ready = a_ready_int;
    assign bus.b_ready = b_ready_int;
    assign bus.wr_en   = wr_en_reg;
    assign bus.w1      = w1_reg;
    assign bus.data    = data_reg;
    assign bus.busy    = busy_vec;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against an age-stamp reference model.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();
    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic set_idle();
        bus.flush   = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_rd    = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_rd    = '0;
        bus.b_data  = '0;
    endtask

    task automatic drive_a(input logic [AW-1:0] rd, input logic [DW-1:0] dat);
        bus.a_valid = 1'b1;
        bus.a_rd    = rd;
        bus.a_data  = dat;
    endtask

    task automatic drive_b(input logic [AW-1:0] rd, input logic [DW-1:0] dat);
        bus.b_valid = 1'b1;
        bus.b_rd    = rd;
        bus.b_data  = dat;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_a(5'd1, 32'h1);
        drive_b(5'd2, 32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk_cnt++; if (bus.a_ready !== 1'b0) $display("FAIL reset_a_ready: got %0b want 0", bus.a_ready); else pass_cnt++;
            chk_cnt++; if (bus.b_ready !== 1'b0) $display("FAIL reset_b_ready: got %0b want 0", bus.b_ready); else pass_cnt++;
            chk_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", bus.wr_en); else pass_cnt++;
            chk_cnt++; if (bus.busy !== '0) $display("FAIL reset_busy: got %h want 0", bus.busy); else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b1; #1;
        chk_cnt++; if (bus.a_ready !== 1'b1) $display("FAIL release_a_ready: got %0b want 1", bus.a_ready); else pass_cnt++;
        chk_cnt++; if (bus.b_ready !== 1'b1) $display("FAIL release_b_ready: got %0b want 1", bus.b_ready); else pass_cnt++;
        @(negedge clk);
        set_idle(); #1;
        chk_cnt++; if (bus.busy !== 32'h6) $display("FAIL release_busy: got %h want 00000006", bus.busy); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd1) $display("FAIL pre_async_write: got en=%0b w1=%0d want en=1 w1=1", bus.wr_en, bus.w1); else pass_cnt++;
        #1 rst = 1'b0;
        #1;
        chk_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL async_wr_en: got %0b want 0", bus.wr_en); else pass_cnt++;
        chk_cnt++; if (bus.busy !== '0) $display("FAIL async_busy: got %h want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.w1 !== '0 || bus.data !== '0) $display("FAIL async_out: got w1=%0d data=%h want 0", bus.w1, bus.data); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_single_port();
        do_reset();
        drive_a(5'd5, 32'hDEADBEEF); #1;
        chk_cnt++; if (bus.a_ready !== 1'b1) $display("FAIL single_a_ready: got %0b want 1", bus.a_ready); else pass_cnt++;
        @(negedge clk); set_idle(); #1;
        chk_cnt++; if (bus.busy[5] !== 1'b1 || bus.wr_en !== 1'b0) $display("FAIL single_c1: got busy5=%0b en=%0b want 1 0", bus.busy[5], bus.wr_en); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd5 || bus.data !== 32'hDEADBEEF) $display("FAIL single_write: got en=%0b w1=%0d data=%h want 1 5 deadbeef", bus.wr_en, bus.w1, bus.data); else pass_cnt++;
        chk_cnt++; if (bus.busy[5] !== 1'b1) $display("FAIL single_c2_busy: got %0b want 1", bus.busy[5]); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.busy !== '0 || bus.wr_en !== 1'b0) $display("FAIL single_c3: got busy=%h en=%0b want 0 0", bus.busy, bus.wr_en); else pass_cnt++;
        $display("test_single_port done");
    endtask

    task automatic test_tie_rr();
        do_reset();
        drive_a(5'd3, 32'h11); drive_b(5'd4, 32'h22); #1;
        chk_cnt++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) $display("FAIL tie_c0_ready: got %0b%0b want 11", bus.a_ready, bus.b_ready); else pass_cnt++;
        @(negedge clk); set_idle(); #1;
        chk_cnt++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) $display("FAIL tie_c1_ready: got %0b%0b want 10", bus.a_ready, bus.b_ready); else pass_cnt++;
        @(negedge clk); drive_a(5'd3, 32'h11); drive_b(5'd4, 32'h22); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd3 || bus.data !== 32'h11) $display("FAIL tie_w0: got en=%0b w1=%0d data=%h want 1 3 11", bus.wr_en, bus.w1, bus.data); else pass_cnt++;
        chk_cnt++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) $display("FAIL tie_c2_ready: got %0b%0b want 11", bus.a_ready, bus.b_ready); else pass_cnt++;
        @(negedge clk); set_idle(); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd4 || bus.data !== 32'h22) $display("FAIL tie_w1: got en=%0b w1=%0d data=%h want 1 4 22", bus.wr_en, bus.w1, bus.data); else pass_cnt++;
        chk_cnt++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) $display("FAIL tie_c3_ready: got %0b%0b want 01", bus.a_ready, bus.b_ready); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd4) $display("FAIL tie_w2: got en=%0b w1=%0d want 1 4", bus.wr_en, bus.w1); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd3) $display("FAIL tie_w3: got en=%0b w1=%0d want 1 3", bus.wr_en, bus.w1); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL tie_idle: got %0b want 0", bus.wr_en); else pass_cnt++;
        $display("test_tie_rr done");
    endtask

    task automatic test_waw();
        do_reset();
        drive_b(5'd7, 32'hAA); #1;
        @(negedge clk); set_idle(); drive_a(5'd7, 32'hBB); #1;
        chk_cnt++; if (bus.a_ready !== 1'b1 || bus.busy[7] !== 1'b1) $display("FAIL waw_c1: got rdy=%0b busy7=%0b want 1 1", bus.a_ready, bus.busy[7]); else pass_cnt++;
        @(negedge clk); set_idle(); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd7 || bus.data !== 32'hAA) $display("FAIL waw_first: got en=%0b w1=%0d data=%h want 1 7 aa", bus.wr_en, bus.w1, bus.data); else pass_cnt++;
        chk_cnt++; if (bus.busy[7] !== 1'b1) $display("FAIL waw_busy_c2: got %0b want 1", bus.busy[7]); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd7 || bus.data !== 32'hBB) $display("FAIL waw_second: got en=%0b w1=%0d data=%h want 1 7 bb", bus.wr_en, bus.w1, bus.data); else pass_cnt++;
        chk_cnt++; if (bus.busy[7] !== 1'b1) $display("FAIL waw_busy_c3: got %0b want 1", bus.busy[7]); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++; if (bus.wr_en !== 1'b0 || bus.busy !== '0 || bus.data !== 32'hBB) $display("FAIL waw_done: got en=%0b busy=%h data=%h want 0 0 bb", bus.wr_en, bus.busy, bus.data); else pass_cnt++;
        $display("test_waw done");
    endtask

    task automatic test_x0_drop();
        do_reset();
        drive_a(5'd0, 32'hFFFFFFFF); #1;
        chk_cnt++; if (bus.a_ready !== 1'b1) $display("FAIL x0_ready: got %0b want 1", bus.a_ready); else pass_cnt++;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); set_idle(); #1;
            chk_cnt++; if (bus.wr_en !== 1'b0 || bus.busy !== '0) $display("FAIL x0_c%0d: got en=%0b busy=%h want 0 0", c, bus.wr_en, bus.busy); else pass_cnt++;
        end
        $display("test_x0_drop done");
    endtask

    task automatic test_flush();
        do_reset();
        drive_a(5'd3, 32'h11); drive_b(5'd4, 32'h22); #1;
        @(negedge clk); set_idle(); drive_a(5'd5, 32'h55); #1;
        chk_cnt++; if (bus.a_ready !== 1'b1) $display("FAIL flush_refill_ready: got %0b want 1", bus.a_ready); else pass_cnt++;
        @(negedge clk);
        bus.flush = 1'b1; drive_a(5'd6, 32'h66); drive_b(5'd8, 32'h88); #1;
        chk_cnt++; if (bus.wr_en !== 1'b1 || bus.w1 !== 5'd3 || bus.data !== 32'h11) $display("FAIL flush_inflight: got en=%0b w1=%0d data=%h want 1 3 11", bus.wr_en, bus.w1, bus.data); else pass_cnt++;
        chk_cnt++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) $display("FAIL flush_ready: got %0b%0b want 00", bus.a_ready, bus.b_ready); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 32'h38) $display("FAIL flush_busy_c2: got %h want 00000038", bus.busy); else pass_cnt++;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk); set_idle(); #1;
            chk_cnt++; if (bus.wr_en !== 1'b0 || bus.busy !== '0) $display("FAIL flush_c%0d: got en=%0b busy=%h want 0 0", c, bus.wr_en, bus.busy); else pass_cnt++;
        end
        $display("test_flush done");
    endtask

    // Reference: each buffered entry carries its acceptance cycle; the oldest
    // wins, equal stamps alternate through a tie-break bit.
    task automatic test_random();
        bit            mv[2];
        logic [AW-1:0] mrd[2];
        logic [DW-1:0] mdat[2];
        int            mst[2];
        bit            mrr;
        bit            men;
        logic [AW-1:0] mw1;
        logic [DW-1:0] mdata;
        logic [NR-1:0] ebusy;
        bit            fl, av, bv, erdy[2], tied;
        logic [AW-1:0] ard, brd;
        logic [DW-1:0] adat, bdat;
        int            win, bad;
        do_reset();
        mv = '{0, 0}; mrd = '{0, 0}; mdat = '{0, 0}; mst = '{0, 0};
        mrr = 0; men = 0; mw1 = '0; mdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc != 0) @(negedge clk);
            fl   = ($urandom_range(0, 19) == 0);
            av   = ($urandom_range(0, 2) != 0);
            bv   = ($urandom_range(0, 2) != 0);
            ard  = AW'($urandom_range(0, 7));
            brd  = AW'($urandom_range(0, 7));
            adat = $urandom;
            bdat = $urandom;
            bus.flush = fl;
            bus.a_valid = av; bus.a_rd = ard; bus.a_data = adat;
            bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bdat;
            win = -1;
            if (mv[0] && mv[1]) win = (mst[0] < mst[1]) ? 0 : (mst[1] < mst[0]) ? 1 : int'(mrr);
            else if (mv[0]) win = 0;
            else if (mv[1]) win = 1;
            tied = mv[0] && mv[1] && (mst[0] == mst[1]);
            erdy[0] = !fl && (!mv[0] || win == 0);
            erdy[1] = !fl && (!mv[1] || win == 1);
            ebusy = '0;
            for (int p = 0; p < 2; p++) if (mv[p]) ebusy[mrd[p]] = 1'b1;
            if (men) ebusy[mw1] = 1'b1;
            #1;
            bad = 0;
            chk_cnt++;
            if (bus.a_ready !== erdy[0] || bus.b_ready !== erdy[1]) bad = 1;
            if (bus.wr_en !== men || bus.w1 !== mw1 || bus.data !== mdata) bad = 1;
            if (bus.busy !== ebusy) bad = 1;
            if (bad != 0)
                $display("FAIL random_c%0d: got rdy=%0b%0b en=%0b w1=%0d data=%h busy=%h want rdy=%0b%0b en=%0b w1=%0d data=%h busy=%h",
                         cyc, bus.a_ready, bus.b_ready, bus.wr_en, bus.w1, bus.data, bus.busy,
                         erdy[0], erdy[1], men, mw1, mdata, ebusy);
            else pass_cnt++;
            if (!fl && win >= 0) begin
                men = 1; mw1 = mrd[win]; mdata = mdat[win]; mv[win] = 0;
                if (tied) mrr = !mrr;
            end else begin
                men = 0;
            end
            if (fl) begin
                mv[0] = 0; mv[1] = 0;
            end else begin
                if (av && erdy[0] && ard != '0) begin mv[0] = 1; mrd[0] = ard; mdat[0] = adat; mst[0] = cyc; end
                if (bv && erdy[1] && brd != '0) begin mv[1] = 1; mrd[1] = brd; mdat[1] = bdat; mst[1] = cyc; end
            end
        end
        @(negedge clk);
        set_idle();
        $display("test_random done");
    endtask

    initial begin
        set_idle();
        test_reset();
        test_single_port();
        test_tie_rr();
        test_waw();
        test_x0_drop();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
